// File: rtl/pp_input_cond.sv
// Button conditioning for PP_1: two-flop sync, debounce, press pulses.
// A y press colliding with an x press is deferred one cycle.
module pp_input_cond #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_x,
  input  logic btn_y,
  output logic x,
  output logic y,
  output logic x_stable,
  output logic y_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] stable_q;
  logic [1:0] stable_d;
  logic [1:0] press;

  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;

  logic x_q, x_d;
  logic y_q, y_d;
  logic y_pend_q, y_pend_d;
  logic y_req;

  // Index 0 is the x channel, index 1 the y channel.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      press[i]    = 1'b0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_q[i];
          press[i]    = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // x always wins a collision; y waits in y_pend.
  always_comb begin
    y_req    = y_pend_q | press[1];
    x_d      = press[0];
    y_d      = y_req & ~press[0];
    y_pend_d = y_req & press[0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      y_pend_q <= 1'b0;
    end else begin
      meta_q   <= {btn_y, btn_x};
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      y_pend_q <= y_pend_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign x_stable = stable_q[0];
  assign y_stable = stable_q[1];

endmodule
